// File: rtl/rx_uart_frame.sv
// 8N1 UART receiver: synchronised input, start-edge detect, mid-bit sampling,
// byte delivery with one-cycle done / frame-error strobes.
module rx_uart_frame #(
  parameter int BPS_T     = 52,
  parameter int HALF_T    = 26,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RX_Pin_In,
  input  logic                 RX_En_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 RX_Err_Sig,
  output logic                 RX_Busy
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [12:0]   LAST_CNT = 13'(BPS_T - 1);
  localparam logic [12:0]   HALF_CNT = 13'(HALF_T);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_reg, state_next;
  logic                   meta_reg, rx_s, rx_d;
  logic [12:0]            cnt_reg;
  logic [IW-1:0]          idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   done_reg, done_next;
  logic                   err_reg, err_next;
  logic                   fall, sample;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      meta_reg <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
    end else begin
      meta_reg <= RX_Pin_In;
      rx_s     <= meta_reg;
      rx_d     <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  // The counter restarts with each frame and then free-runs across the start,
  // data and stop bits, so every sample stays HALF_T into its bit period.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_reg <= '0;
    end else if (state_reg == IDLE || state_next == IDLE) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST_CNT) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 13'd1;
    end
  end

  assign sample = (state_reg != IDLE) && (cnt_reg == HALF_CNT);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        idx_next = '0;
        if (RX_En_Sig && fall) state_next = START;
      end
      START: begin
        if (sample) begin
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          idx_next   = idx_reg + IW'(1);
          if (idx_reg == LAST_IDX) state_next = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_s) begin
            data_next = shift_reg;
            done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Dropping the enable mid-frame abandons the frame silently.
    if (state_reg != IDLE && !RX_En_Sig) begin
      state_next = IDLE;
      data_next  = data_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
    end
  end

  assign RX_Data     = data_reg;
  assign RX_Done_Sig = done_reg;
  assign RX_Err_Sig  = err_reg;
  assign RX_Busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_uart_frame.sv
// Self-checking bench for rx_uart_frame: vector table, corner-case sequences,
// and randomized frames checked against a frame-level reference model.
module tb_rx_uart_frame;
  localparam int BPS_T = 52;

  logic       CLK, RSTn, RX_Pin_In, RX_En_Sig;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig, RX_Err_Sig, RX_Busy;

  int   tests = 0, fails = 0;
  int   done_cnt = 0, err_cnt = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] model_data;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[4];

  rx_uart_frame #(.BPS_T(52), .HALF_T(26), .DATA_BITS(8)) dut (
    .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(RX_Pin_In), .RX_En_Sig(RX_En_Sig),
    .RX_Data(RX_Data), .RX_Done_Sig(RX_Done_Sig), .RX_Err_Sig(RX_Err_Sig),
    .RX_Busy(RX_Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor: counts pulses and enforces exclusivity and single-cycle width.
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTn) begin
        if (RX_Done_Sig) done_cnt++;
        if (RX_Err_Sig) err_cnt++;
        if (RX_Done_Sig || RX_Err_Sig) begin
          check("strobe_exclusive", {31'd0, RX_Done_Sig & RX_Err_Sig}, 32'd0);
          check("strobe_width", {31'd0, prev_strobe}, 32'd0);
        end
        prev_strobe = RX_Done_Sig | RX_Err_Sig;
      end else begin
        prev_strobe = 1'b0;
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bit_period(input logic b);
    RX_Pin_In = b;
    wait_clks(BPS_T);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    bit_period(stop);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic stop, input int gap,
                           input logic exp_done, input logic exp_err, input logic [7:0] exp_data);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(d, stop);
    $display("[TB] frame 0x%02h stop=%0d -> done=%0d err=%0d data=0x%02h (exp %0d %0d 0x%02h)",
             d, stop, done_cnt - d0, err_cnt - e0, RX_Data, exp_done, exp_err, exp_data);
    check("done_pulses", done_cnt - d0, {31'd0, exp_done});
    check("err_pulses", err_cnt - e0, {31'd0, exp_err});
    check("rx_data", {24'd0, RX_Data}, {24'd0, exp_data});
    RX_Pin_In = 1'b1;
    if (gap > 0) wait_clks(gap);
  endtask

  initial begin
    int d0, e0;
    logic [7:0] rd;
    logic rs;
    int gap;

    vecs[0] = '{8'h55, 1'b1, 10, 1'b1, 1'b0, 8'h55};
    vecs[1] = '{8'hA3, 1'b1, 0,  1'b1, 1'b0, 8'hA3};
    vecs[2] = '{8'h0F, 1'b1, 20, 1'b1, 1'b0, 8'h0F};
    vecs[3] = '{8'h3C, 1'b0, 20, 1'b0, 1'b1, 8'h0F};

    RSTn = 1'b0; RX_En_Sig = 1'b1; RX_Pin_In = 1'b1;
    #23;
    check("reset_data", {24'd0, RX_Data}, 32'd0);
    check("reset_done", {31'd0, RX_Done_Sig}, 32'd0);
    check("reset_err", {31'd0, RX_Err_Sig}, 32'd0);
    check("reset_busy", {31'd0, RX_Busy}, 32'd0);
    #4 RSTn = 1'b1;
    @(posedge CLK); #1;
    wait_clks(5);
    $display("[TB] reset released");

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].data, vecs[i].stop, vecs[i].gap,
                vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_data);
    model_data = 8'h0F;

    // Short low glitch on an idle line: false start, no strobes.
    d0 = done_cnt; e0 = err_cnt;
    RX_Pin_In = 1'b0;
    wait_clks(10);
    RX_Pin_In = 1'b1;
    wait_clks(5);
    check("glitch_busy_high", {31'd0, RX_Busy}, 32'd1);
    wait_clks(25);
    check("glitch_busy_low", {31'd0, RX_Busy}, 32'd0);
    wait_clks(40);
    check("glitch_done", done_cnt - d0, 32'd0);
    check("glitch_err", err_cnt - e0, 32'd0);
    $display("[TB] glitch: busy=%0d done=%0d err=%0d", RX_Busy, done_cnt - d0, err_cnt - e0);

    // Enable dropped during bit 4 of 0xFF.
    d0 = done_cnt; e0 = err_cnt;
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'b1);
    RX_Pin_In = 1'b1;
    wait_clks(20);
    RX_En_Sig = 1'b0;
    wait_clks(2);
    check("abort_busy", {31'd0, RX_Busy}, 32'd0);
    wait_clks(30);
    for (int i = 5; i < 9; i++) bit_period(1'b1);
    check("abort_done", done_cnt - d0, 32'd0);
    check("abort_err", err_cnt - e0, 32'd0);
    check("abort_data", {24'd0, RX_Data}, {24'd0, model_data});
    $display("[TB] abort: busy=%0d data=0x%02h", RX_Busy, RX_Data);
    RX_En_Sig = 1'b1;
    wait_clks(5);
    run_frame(8'h81, 1'b1, 10, 1'b1, 1'b0, 8'h81);
    model_data = 8'h81;

    // Asynchronous reset during bit 2 of 0xFF.
    d0 = done_cnt; e0 = err_cnt;
    bit_period(1'b0);
    bit_period(1'b1);
    bit_period(1'b1);
    RX_Pin_In = 1'b1;
    wait_clks(10);
    #3 RSTn = 1'b0;
    #1;
    check("midreset_data", {24'd0, RX_Data}, 32'd0);
    check("midreset_done", {31'd0, RX_Done_Sig}, 32'd0);
    check("midreset_err", {31'd0, RX_Err_Sig}, 32'd0);
    check("midreset_busy", {31'd0, RX_Busy}, 32'd0);
    $display("[TB] mid-frame reset: data=0x%02h busy=%0d", RX_Data, RX_Busy);
    #2 RSTn = 1'b1;
    wait_clks(42);
    for (int i = 3; i < 9; i++) bit_period(1'b1);
    check("midreset_no_done", done_cnt - d0, 32'd0);
    check("midreset_no_err", err_cnt - e0, 32'd0);
    model_data = 8'h00;
    wait_clks(10);
    run_frame(8'h7E, 1'b1, 10, 1'b1, 1'b0, 8'h7E);
    model_data = 8'h7E;

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 16; n++) begin
      rd  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 4) != 0);
      gap = rs ? int'($urandom_range(0, 20)) : int'($urandom_range(3, 20));
      if (rs) model_data = rd;
      run_frame(rd, rs, gap, rs, ~rs, model_data);
    end

    wait_clks(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
